velocity_cell_stream_ctrl: RTL and testbench

- Sits directly upstream of one per-cell velocity memory (single-port RAM, {vz,vy,vx} words, address 0 = particle count).
- Drives that memory's address/data/rden/wren and consumes its q output.
- On start, reads the cell's particle count, then streams velocities 1..N to the motion-update pipeline over a valid/ready handshake.
- Concurrently accepts write-back of updated velocities from motion update and arbitrates them onto the same single port.

---
 rtl/velocity_cell_stream_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_velocity_cell_stream_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/velocity_cell_stream_ctrl.sv
// Streams one cell's velocity words (ids 1..N) out of a single-port RAM and merges
// motion-update write-backs onto the same port. Optional range check: VELOCITY_STREAM_WB_CHECK_EN.
module velocity_cell_stream_ctrl #(
    parameter int DATA_WIDTH     = 96,
    parameter int PARTICLE_NUM   = 220,
    parameter int ADDR_WIDTH     = 8,
    parameter int MEM_RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_num,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_particle_id,
    output logic [DATA_WIDTH-1:0] out_velocity,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [ADDR_WIDTH-1:0] wb_particle_id,
    input  logic [DATA_WIDTH-1:0] wb_velocity,
    output logic                  wb_err
);
    localparam int FIFO_DEPTH = MEM_RD_LATENCY + 1;
    localparam int CW = $clog2(2 * FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    typedef enum logic [2:0] {S_IDLE, S_RD_CNT, S_WAIT_CNT, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_particle_num;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [3:0]            r_wait;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_wb_last;
    logic                  r_pipe_v    [MEM_RD_LATENCY];
    logic [ADDR_WIDTH-1:0] r_pipe_addr [MEM_RD_LATENCY];
    logic [ADDR_WIDTH-1:0] r_fifo_id   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_vel  [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_fifo_cnt;

    logic [CW-1:0]         w_inflight;
    logic [CW-1:0]         w_credit;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_hazard;
    logic                  w_read_want;
    logic                  w_issue;
    logic                  w_wb_accept;
    logic                  w_wb_bad;
    logic                  w_drained;
    logic [ADDR_WIDTH-1:0] w_cnt_clamp;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign out_valid       = (r_fifo_cnt != '0);
    assign out_particle_id = r_fifo_id[r_rd_ptr];
    assign out_velocity    = r_fifo_vel[r_rd_ptr];
    assign busy            = r_busy;
    assign done            = r_done;
    assign particle_num    = r_particle_num;
    assign w_pop           = out_valid && out_ready;
    assign w_push          = r_pipe_v[MEM_RD_LATENCY-1];
    assign w_cnt_clamp     = (mem_q[ADDR_WIDTH-1:0] > MAX_CNT) ? MAX_CNT : mem_q[ADDR_WIDTH-1:0];

    always_comb begin
        w_inflight = '0;
        w_hazard   = (r_state == S_WAIT_CNT) && (wb_particle_id == '0);
        for (int i = 0; i < MEM_RD_LATENCY; i++) begin
            w_inflight = w_inflight + CW'(r_pipe_v[i]);
            if (r_pipe_v[i] && (r_pipe_addr[i] == wb_particle_id))
                w_hazard = 1'b1;
        end
        // A slot freed by this cycle's pop is reusable: keeps 1 item/cycle with depth LAT+1.
        w_credit    = r_fifo_cnt + w_inflight - CW'(w_pop);
        w_read_want = (r_state == S_STREAM) && (w_credit < CW'(FIFO_DEPTH));
        // Write wins a collision, but the read gets the following cycle so it only slips once.
        wb_ready    = (r_state inside {S_IDLE, S_WAIT_CNT, S_STREAM, S_DRAIN}) && !w_hazard
                      && !(r_wb_last && w_read_want);
        w_wb_accept = wb_valid && wb_ready;
        w_issue     = w_read_want && !w_wb_accept;
        mem_wren    = w_wb_accept && !w_wb_bad;
        mem_rden    = (r_state == S_RD_CNT) || w_issue;
        mem_address = '0;
        if (w_wb_accept)
            mem_address = wb_particle_id;
        else if (w_issue)
            mem_address = r_rd_addr;
        mem_data    = mem_wren ? wb_velocity : '0;
        w_drained   = (w_inflight == '0) &&
                      ((r_fifo_cnt == '0) || ((r_fifo_cnt == CW'(1)) && w_pop));
    end

    // state      | meaning
    // S_IDLE     | waiting for start
    // S_RD_CNT   | read of address 0 (particle count) issued
    // S_WAIT_CNT | waiting for the count to return, then latch it
    // S_STREAM   | issuing reads 1..N under FIFO credit
    // S_DRAIN    | all reads issued, emptying pipeline and FIFO
    // S_DONE     | one-cycle done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_particle_num <= '0;
            r_rd_addr      <= '0;
            r_wait         <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_state <= S_RD_CNT;
                    r_busy  <= 1'b1;
                end
                S_RD_CNT: begin
                    r_state <= S_WAIT_CNT;
                    r_wait  <= 4'(MEM_RD_LATENCY - 1);
                end
                S_WAIT_CNT: begin
                    if (r_wait == '0) begin
                        r_particle_num <= w_cnt_clamp;
                        r_rd_addr      <= ADDR_WIDTH'(1);
                        if (w_cnt_clamp == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_STREAM;
                        end
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                S_STREAM: if (w_issue) begin
                    r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
                    if (r_rd_addr == r_particle_num)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: if (w_drained) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_RD_LATENCY; i++) begin
                r_pipe_v[i]    <= 1'b0;
                r_pipe_addr[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_id[i]  <= '0;
                r_fifo_vel[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            r_wb_last  <= 1'b0;
        end else begin
            r_wb_last      <= w_wb_accept;
            r_pipe_v[0]    <= w_issue;
            r_pipe_addr[0] <= r_rd_addr;
            for (int i = 1; i < MEM_RD_LATENCY; i++) begin
                r_pipe_v[i]    <= r_pipe_v[i-1];
                r_pipe_addr[i] <= r_pipe_addr[i-1];
            end
            if (w_push) begin
                r_fifo_id[r_wr_ptr]  <= r_pipe_addr[MEM_RD_LATENCY-1];
                r_fifo_vel[r_wr_ptr] <= mem_q;
                r_wr_ptr             <= ptr_inc(r_wr_ptr);
            end
            if (w_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

`ifdef VELOCITY_STREAM_WB_CHECK_EN
    logic r_wb_err;
    assign w_wb_bad = (wb_particle_id == '0) || (wb_particle_id > r_particle_num);
    assign wb_err   = r_wb_err;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_wb_err <= 1'b0;
        else if (w_wb_accept && w_wb_bad)
            r_wb_err <= 1'b1;
    end
`else
    assign w_wb_bad = 1'b0;
    assign wb_err   = 1'b0;
`endif

endmodule

// File: tb/tb_velocity_cell_stream_ctrl.sv
// Directed bench for velocity_cell_stream_ctrl with a 2-cycle single-port RAM model.
// Exercises the VELOCITY_STREAM_WB_CHECK_EN option when that macro is defined.
module tb_velocity_cell_stream_ctrl;
    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;

    logic          clk = 1'b0;
    logic          rst, start, out_ready = 1'b1, wb_valid;
    logic          busy, done, mem_rden, mem_wren, out_valid, wb_ready, wb_err;
    logic [AW-1:0] particle_num, mem_address, out_particle_id, wb_particle_id;
    logic [DW-1:0] mem_data, mem_q = '0, out_velocity, wb_velocity;

    logic [DW-1:0] mem [PN];
    logic [AW-1:0] ram_addr = '0;
    logic          ram_rd = 1'b0;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, done_cnt = 0, both_cnt = 0, stall_err = 0, valid_cnt = 0, fifo_max = 0, acc_cnt = 0;
    logic [AW-1:0] mon_id [$];
    logic [DW-1:0] mon_vel [$];
    int            mon_cyc [$];
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_id = '0;
    logic [DW-1:0] prev_vel = '0;
    int            rdy_mode = 0, rdy_idx = 0;
    bit            rdy_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [DW-1:0] AA;

    velocity_cell_stream_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .particle_num(particle_num), .mem_address(mem_address), .mem_data(mem_data),
        .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_particle_id(out_particle_id),
        .out_velocity(out_velocity), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_particle_id(wb_particle_id), .wb_velocity(wb_velocity), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (mem_wren) mem[mem_address] <= mem_data;
        ram_addr <= mem_address;
        ram_rd   <= mem_rden;
        if (ram_rd) mem_q <= mem[ram_addr];
    end

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) begin
            out_ready = rdy_pat[rdy_idx % 6];
            rdy_idx++;
        end else begin
            out_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (mem_rden && mem_wren) both_cnt++;
            if (done) done_cnt++;
            if (out_valid) valid_cnt++;
            if (wb_valid && wb_ready) acc_cnt++;
            if (int'(dut.r_fifo_cnt) > fifo_max) fifo_max = int'(dut.r_fifo_cnt);
            if (prev_stall && (!out_valid || out_particle_id != prev_id || out_velocity != prev_vel))
                stall_err++;
            if (out_valid && out_ready) begin
                mon_id.push_back(out_particle_id);
                mon_vel.push_back(out_velocity);
                mon_cyc.push_back(cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_id    = out_particle_id;
            prev_vel   = out_velocity;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] pat(input int k);
        return {32'(k + 32'h300), 32'(k + 32'h200), 32'(k + 32'h100)};
    endfunction

    function automatic logic [DW-1:0] exp_vel(input int k, input bit alt3);
        return (alt3 && k == 3) ? AA : pat(k);
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [DW-1:0] d);
        ld_en = 1'b1; ld_addr = AW'(a); ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int restart_at);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (i == restart_at) begin
                tick(); start = 1'b1;
                tick(); start = 1'b0;
            end
        end
        check("done_seen", 128'(seen), 128'(1));
        @(negedge clk);
        check("busy_after_done", 128'(busy), 128'(0));
        check("done_single", 128'(done), 128'(0));
        tick();
    endtask

    task automatic check_items(input int base, input int n, input bit alt3);
        check("n_items", 128'(mon_id.size() - base), 128'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < mon_id.size()) begin
                check("item_id", 128'(mon_id[base+i]), 128'(i + 1));
                check("item_vel", 128'(mon_vel[base+i]), 128'(exp_vel(i + 1, alt3)));
            end
        end
    endtask

    initial begin
        int  b, d0, v0, s0, bc, ac, stall;
        bit  got;
        AA = {24{4'hA}};
        rst = 1'b1; start = 1'b0; wb_valid = 1'b0; wb_particle_id = '0; wb_velocity = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_rden", 128'(mem_rden), 128'(0));
        check("rst_wren", 128'(mem_wren), 128'(0));
        check("rst_pnum", 128'(particle_num), 128'(0));
        check("rst_wb_err", 128'(wb_err), 128'(0));
        check("rst_out_vel", 128'(out_velocity), 128'(0));
        tick();
        rst = 1'b0;
        for (int a = 0; a < PN; a++) load(a, (a == 0) ? DW'(5) : pat(a));

        // basic pass, full throughput, with an ignored start while busy
        b = mon_id.size(); d0 = done_cnt;
        pulse_start();
        wait_done(3);
        check("t1_pnum", 128'(particle_num), 128'(5));
        check_items(b, 5, 1'b0);
        if (mon_cyc.size() >= b + 5)
            check("t1_consecutive", 128'(mon_cyc[b+4] - mon_cyc[b]), 128'(4));
        check("t1_done_cnt", 128'(done_cnt - d0), 128'(1));

        // backpressure pattern
        rdy_mode = 1;
        b = mon_id.size(); s0 = stall_err; d0 = done_cnt;
        pulse_start();
        wait_done(-1);
        rdy_mode = 0;
        check_items(b, 5, 1'b0);
        check("t2_stable", 128'(stall_err - s0), 128'(0));
        check("t2_fifo_le3", 128'(fifo_max <= 3), 128'(1));
        check("t2_done_cnt", 128'(done_cnt - d0), 128'(1));

        // empty cell
        load(0, '0);
        b = mon_id.size(); v0 = valid_cnt; d0 = done_cnt;
        pulse_start();
        wait_done(-1);
        check("t3_pnum", 128'(particle_num), 128'(0));
        check_items(b, 0, 1'b0);
        check("t3_no_valid", 128'(valid_cnt - v0), 128'(0));
        check("t3_done_cnt", 128'(done_cnt - d0), 128'(1));

        // over-range count clamps to PARTICLE_NUM-1
        load(0, DW'(250));
        b = mon_id.size();
        pulse_start();
        wait_done(-1);
        check("t4_pnum", 128'(particle_num), 128'(219));
        check_items(b, 219, 1'b0);

        // write-back hazard on a read in flight
        load(0, DW'(5));
        b = mon_id.size();
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (mem_rden && !mem_wren && mem_address == AW'(3)) got = 1'b1;
        end
        check("t5_rd3_seen", 128'(got), 128'(1));
        tick();
        wb_valid = 1'b1; wb_particle_id = AW'(3); wb_velocity = AA;
        got = 1'b0; stall = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (wb_ready) got = 1'b1;
            else stall++;
        end
        check("t5_wb_accepted", 128'(got), 128'(1));
        check("t5_hazard_cycles", 128'(stall), 128'(2));
        check("t5_wren", 128'(mem_wren), 128'(1));
        check("t5_rden_low", 128'(mem_rden), 128'(0));
        check("t5_addr", 128'(mem_address), 128'(3));
        check("t5_data", 128'(mem_data), 128'(AA));
        tick();
        wb_valid = 1'b0;
        wait_done(-1);
        check_items(b, 5, 1'b0);
        check("t5_mem3", 128'(mem[3]), 128'(AA));
        b = mon_id.size();
        pulse_start();
        wait_done(-1);
        check_items(b, 5, 1'b1);

        // write-back held valid through a whole pass
        b = mon_id.size(); bc = both_cnt; ac = acc_cnt;
        wb_valid = 1'b1; wb_particle_id = AW'(3); wb_velocity = AA;
        pulse_start();
        wait_done(-1);
        wb_valid = 1'b0;
        check("t6_rden_wren_excl", 128'(both_cnt - bc), 128'(0));
        check("t6_wb_accepts", 128'(acc_cnt - ac > 0), 128'(1));
        check_items(b, 5, 1'b1);

        // reset in the middle of a pass
        d0 = done_cnt;
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        check("t7_streaming", 128'(got), 128'(1));
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("t7_busy", 128'(busy), 128'(0));
        check("t7_out_valid", 128'(out_valid), 128'(0));
        check("t7_rden", 128'(mem_rden), 128'(0));
        check("t7_pnum", 128'(particle_num), 128'(0));
        tick();
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t7_no_done", 128'(done_cnt - d0), 128'(0));
        check("t7_idle", 128'(busy), 128'(0));
        tick();
        b = mon_id.size();
        pulse_start();
        wait_done(-1);
        check("t7_recover_pnum", 128'(particle_num), 128'(5));
        check_items(b, 5, 1'b1);

`ifdef VELOCITY_STREAM_WB_CHECK_EN
        wb_valid = 1'b1; wb_particle_id = AW'(0); wb_velocity = AA;
        @(negedge clk);
        check("t8_id0_ready", 128'(wb_ready), 128'(1));
        check("t8_id0_wren", 128'(mem_wren), 128'(0));
        tick();
        wb_particle_id = AW'(7);
        @(negedge clk);
        check("t8_err_set", 128'(wb_err), 128'(1));
        check("t8_id7_wren", 128'(mem_wren), 128'(0));
        tick();
        wb_valid = 1'b0;
        @(negedge clk);
        check("t8_err_sticky", 128'(wb_err), 128'(1));
        check("t8_addr0", 128'(mem[0]), 128'(5));
        check("t8_addr7", 128'(mem[7]), 128'(pat(7)));
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("t8_err_cleared", 128'(wb_err), 128'(0));
        tick();
        rst = 1'b0;
`else
        check("t8_wb_err_tied", 128'(wb_err), 128'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
